spi_cfg_sequencer: RTL and testbench
====================================

SPI_CFG_SEQUENCER -- requirements
Module: spi_cfg_sequencer

Interface
REQ-001 The block SHALL take parameter GAP_CYCLES, default 72, giving the idle cycles after each CMD write so the SPI byte can complete.
REQ-002 The block SHALL take parameter TIMEOUT_CYCLES, default 16, giving the maximum number of ACCESS cycles spent waiting for PREADY.
REQ-003 The block SHALL have one clock, i_PCLK, and a synchronous active-high reset, i_PRESET; both SHALL be listed as the first ports.
REQ-004 The block SHALL have these ports: i_PCLK in 1 clock; i_PRESET in 1 sync reset; i_START in 1 start pulse; i_MODE in 2 SPI mode; i_SLAVE in 2 slave select; i_SCK in 2 SCK divider; i_CNT_RX in 16 RX counter value; i_CNT_TX in 16 TX counter value; i_OSC_FREQ in 8; i_ARTHUR in 8; i_PREADY in 1 APB ready.
REQ-005 The block SHALL also have: o_PSEL out 1; o_PENABLE out 1; o_PWRITE out 1; o_PADDR out 16; o_PWDATA out 8; o_CONFIG out 1, the slave config-mode strobe; o_BUSY out 1; o_DONE out 1, a one-cycle pulse; o_ERR out 1, a sticky error flag.

Function
REQ-006 On i_START in IDLE, the block SHALL latch every i_* config input in that cycle, then assert o_BUSY and o_CONFIG on the next cycle.
REQ-007 The block SHALL ignore i_START while o_BUSY is 1; latched values SHALL NOT change mid-sequence.
REQ-008 The block SHALL send exactly 10 bytes, in this order: F8, CNT_RX[15:8], CNT_RX[7:0], F9, CNT_TX[15:8], CNT_TX[7:0], FA, OSC_FREQ, FB, ARTHUR.
REQ-009 For each byte, the block SHALL perform three APB writes in order:
- CONFIG: addr 0x0040, data {2'b00, MODE, SLAVE, SCK}.
- TX: addr 0x0044, data = the byte.
- CMD: addr 0x004C, data 0x02.
REQ-010 FSM states SHALL be IDLE, SETUP, ACCESS, HOLD, GAP and FINISH.
REQ-011 SETUP: o_PSEL=1, o_PENABLE=0, o_PWRITE=1, address and data valid; the FSM SHALL move to ACCESS next cycle.
REQ-012 ACCESS: o_PSEL=1 and o_PENABLE=1; the FSM SHALL stay in ACCESS until i_PREADY=1, then go to HOLD.
REQ-013 HOLD: o_PSEL, o_PENABLE and o_PWRITE SHALL all be 0 for exactly one cycle; next state SHALL be SETUP for the next write of the same byte, or GAP after the CMD write.
REQ-014 GAP SHALL last exactly GAP_CYCLES cycles; the FSM SHALL then go to SETUP for the next byte, or to FINISH after byte 9.
REQ-015 FINISH SHALL last one cycle: o_DONE=1, o_CONFIG=0, o_BUSY=0; the FSM SHALL then return to IDLE.
REQ-016 With i_PREADY held at 1, each byte SHALL take 9+GAP_CYCLES cycles, so the full sequence SHALL take 10*(9+GAP_CYCLES) cycles from the first SETUP to FINISH.
REQ-017 o_PADDR and o_PWDATA SHALL be held stable from SETUP through the end of ACCESS, and SHALL be 0 outside SETUP and ACCESS.
REQ-018 The byte index (0..9) and the gap counter SHALL be sized to hold their maximum values with no wrap; the byte index SHALL clear on every new start.
REQ-019 o_ERR SHALL be cleared only by reset or by an accepted i_START.

Reset
REQ-020 When i_PRESET=1 at a clock edge, the block SHALL go to IDLE, and every output (o_PSEL, o_PENABLE, o_PWRITE, o_PADDR, o_PWDATA, o_CONFIG, o_BUSY, o_DONE, o_ERR) SHALL be 0 on the following cycle.
REQ-021 A reset during any state, including mid-ACCESS, SHALL abort the sequence with no o_DONE pulse.

Configuration
REQ-022 With SPI_CFG_PREADY_TIMEOUT_EN defined: after TIMEOUT_CYCLES consecutive ACCESS cycles with i_PREADY=0, the block SHALL set o_ERR=1, drop o_PSEL, o_PENABLE and o_CONFIG, and return to IDLE with no o_DONE pulse.
REQ-023 Without SPI_CFG_PREADY_TIMEOUT_EN: ACCESS SHALL wait indefinitely, and o_ERR SHALL be tied to 0.

Structure
REQ-024 A shared package spi_cfg_pkg SHALL hold:
- the FSM state enum;
- the address constants ADDR_CONFIG=0x0040, ADDR_TX=0x0044, ADDR_CMD=0x004C;
- CMD_GO=0x02;
- the opcodes F8, F9, FA and FB.
REQ-025 The APB write phase machine (SETUP/ACCESS/HOLD) SHALL be a single sub-module, apb_wr_master, driven by a req/addr/data and done handshake.

Verification
REQ-026 Bench case, nominal: GAP_CYCLES=72, PREADY=1, start with CNT_RX=0x2710, CNT_TX=0x2500, OSC=0x03, ARTHUR=0x0D. Required: TX data sequence F8,27,10,F9,25,00,FA,03,FB,0D; o_DONE exactly 810 cycles after the first SETUP.
REQ-027 Bench case, wait states: PREADY held 0 for 3 cycles on every ACCESS. Required: each write takes 3 extra cycles; addr and data stay stable throughout; sequence completes.
REQ-028 Bench case, start while busy: pulse i_START at byte 4 with different inputs. Required: sequence unaffected; the original values are sent.
REQ-029 Bench case, mid-transfer reset: assert i_PRESET during ACCESS of byte 5. Required: all outputs 0 next cycle; no o_DONE; a new start begins at F8.
REQ-030 Bench case, timeout (SPI_CFG_PREADY_TIMEOUT_EN defined): PREADY stuck at 0. Required: o_ERR=1 after 16 ACCESS cycles; o_CONFIG=0; FSM in IDLE; a new i_START clears o_ERR.
REQ-031 Bench case, back-to-back: i_START in the cycle after o_DONE. Required: the new sequence is accepted; CONFIG write data = {00, MODE, SLAVE, SCK} (e.g. 0x0D for MODE=00, SLAVE=11, SCK=01).

Source files
------------

// File: rtl/spi_cfg_pkg.sv
// spi_cfg_pkg: shared state encoding, APB register map and opcodes for the
// SPI slave configuration sequencer.
// Optional feature macro: SPI_CFG_PREADY_TIMEOUT_EN (enables the PREADY
// wait-state timeout and the sticky error flag).
package spi_cfg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      ACCESS,
      HOLD,
      GAP,
      FINISH
   } spiState_e;

   localparam logic [15:0] ADDR_CONFIG = 16'h0040;
   localparam logic [15:0] ADDR_TX     = 16'h0044;
   localparam logic [15:0] ADDR_CMD    = 16'h004C;

   localparam logic [7:0]  CMD_GO      = 8'h02;

   localparam logic [7:0]  OP_F8       = 8'hF8;
   localparam logic [7:0]  OP_F9       = 8'hF9;
   localparam logic [7:0]  OP_FA       = 8'hFA;
   localparam logic [7:0]  OP_FB       = 8'hFB;

   localparam int          NUM_BYTES   = 10;

`ifdef SPI_CFG_PREADY_TIMEOUT_EN
   localparam bit          TIMEOUT_EN  = 1'b1;
`else
   localparam bit          TIMEOUT_EN  = 1'b0;
`endif

   // Value written to the SPI controller's config register ahead of every byte.
   function automatic logic [7:0] cfgWord(input logic [1:0] mode,
                                          input logic [1:0] slave,
                                          input logic [1:0] sck);
      return {2'b00, mode, slave, sck};
   endfunction

endpackage

// File: rtl/spi_cfg_sequencer_apb.sv
// apb_wr_master: performs one APB write (SETUP -> ACCESS -> HOLD) per request.
// The requester keeps addr_i/data_i stable while the write is in flight; the
// bus outputs are zero whenever no SETUP/ACCESS phase is active.
// A request seen during HOLD chains straight into the next SETUP.
// With SPI_CFG_PREADY_TIMEOUT_EN the ACCESS phase gives up after
// TIMEOUT_CYCLES cycles without PREADY and pulses timeout_o.
module apb_wr_master
   import spi_cfg_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
)
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic [15:0] addr_i,
   input  logic [7:0]  data_i,
   input  logic        pready_i,
   output logic        psel_o,
   output logic        penable_o,
   output logic        pwrite_o,
   output logic [15:0] paddr_o,
   output logic [7:0]  pwdata_o,
   output logic        done_o,
   output logic        timeout_o
);

   localparam int               WAIT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

   spiState_e         stateQ, stateD;
   logic [WAIT_W-1:0] waitQ, waitD;
   logic              busActive;

   // Phase register and ACCESS wait-state counter.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stateQ <= IDLE;
         waitQ  <= '0;
      end else begin
         stateQ <= stateD;
         waitQ  <= waitD;
      end
   end

   // Next phase: SETUP always advances, ACCESS waits for PREADY (or times out).
   always_comb begin
      stateD    = stateQ;
      waitD     = waitQ;
      timeout_o = 1'b0;
      case (stateQ)
         IDLE: begin
            if (req_i) stateD = SETUP;
         end
         SETUP: begin
            waitD  = '0;
            stateD = ACCESS;
         end
         ACCESS: begin
            if (pready_i) begin
               stateD = HOLD;
            end else if (waitQ == WAIT_LAST) begin
               if (TIMEOUT_EN) begin
                  timeout_o = 1'b1;
                  stateD    = IDLE;
               end
            end else begin
               waitD = waitQ + WAIT_W'(1);
            end
         end
         HOLD: begin
            stateD = req_i ? SETUP : IDLE;
         end
         default: begin
            stateD = IDLE;
         end
      endcase
   end

   assign busActive = (stateQ == SETUP) || (stateQ == ACCESS);
   assign psel_o    = busActive;
   assign penable_o = (stateQ == ACCESS);
   assign pwrite_o  = busActive;
   assign paddr_o   = busActive ? addr_i : 16'h0000;
   assign pwdata_o  = busActive ? data_i : 8'h00;
   assign done_o    = (stateQ == HOLD);

endmodule

// File: rtl/spi_cfg_sequencer.sv
// spi_cfg_sequencer: on a start pulse, latches the configuration inputs and
// pushes ten bytes (F8 RX_hi RX_lo F9 TX_hi TX_lo FA OSC FB ARTHUR) to an APB
// SPI controller. Each byte is CONFIG, TX and CMD writes followed by an idle
// gap of GAP_CYCLES so the SPI shift can finish.
// Optional feature macro: SPI_CFG_PREADY_TIMEOUT_EN (abort with sticky o_ERR
// when PREADY stays low for TIMEOUT_CYCLES ACCESS cycles); without it o_ERR is 0.
// The sequencer's SETUP state covers the whole three-write burst; the
// per-write SETUP/ACCESS/HOLD phases live in apb_wr_master.
module spi_cfg_sequencer
   import spi_cfg_pkg::*;
#(
   parameter int GAP_CYCLES     = 72,
   parameter int TIMEOUT_CYCLES = 16
)
(
   input  logic        i_PCLK,
   input  logic        i_PRESET,
   input  logic        i_START,
   input  logic [1:0]  i_MODE,
   input  logic [1:0]  i_SLAVE,
   input  logic [1:0]  i_SCK,
   input  logic [15:0] i_CNT_RX,
   input  logic [15:0] i_CNT_TX,
   input  logic [7:0]  i_OSC_FREQ,
   input  logic [7:0]  i_ARTHUR,
   input  logic        i_PREADY,
   output logic        o_PSEL,
   output logic        o_PENABLE,
   output logic        o_PWRITE,
   output logic [15:0] o_PADDR,
   output logic [7:0]  o_PWDATA,
   output logic        o_CONFIG,
   output logic        o_BUSY,
   output logic        o_DONE,
   output logic        o_ERR
);

   localparam int               GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
   localparam logic [3:0]       LAST_BYTE = 4'(NUM_BYTES - 1);

   spiState_e        stateQ, stateD;
   logic [3:0]       byteIdxQ, byteIdxD;
   logic [1:0]       writeIdxQ, writeIdxD;
   logic [GAP_W-1:0] gapCntQ, gapCntD;
   logic             errQ, errD;
   logic             latchCfg;

   logic [1:0]       modeQ, slaveQ, sckQ;
   logic [15:0]      cntRxQ, cntTxQ;
   logic [7:0]       oscQ, arthurQ;

   logic             wrReq, wrDone, wrTimeout;
   logic [15:0]      wrAddr;
   logic [7:0]       wrData;
   logic [7:0]       txByte;

   // Sequencer state, counters and sticky error flag.
   always_ff @(posedge i_PCLK) begin
      if (i_PRESET) begin
         stateQ    <= IDLE;
         byteIdxQ  <= '0;
         writeIdxQ <= '0;
         gapCntQ   <= '0;
         errQ      <= 1'b0;
      end else begin
         stateQ    <= stateD;
         byteIdxQ  <= byteIdxD;
         writeIdxQ <= writeIdxD;
         gapCntQ   <= gapCntD;
         errQ      <= errD;
      end
   end

   // Configuration snapshot, captured only when a start is accepted.
   always_ff @(posedge i_PCLK) begin
      if (i_PRESET) begin
         modeQ   <= '0;
         slaveQ  <= '0;
         sckQ    <= '0;
         cntRxQ  <= '0;
         cntTxQ  <= '0;
         oscQ    <= '0;
         arthurQ <= '0;
      end else if (latchCfg) begin
         modeQ   <= i_MODE;
         slaveQ  <= i_SLAVE;
         sckQ    <= i_SCK;
         cntRxQ  <= i_CNT_RX;
         cntTxQ  <= i_CNT_TX;
         oscQ    <= i_OSC_FREQ;
         arthurQ <= i_ARTHUR;
      end
   end

   // Sequencing: issue write requests so each SETUP follows immediately,
   // then walk the gap counter and byte index.
   always_comb begin
      stateD    = stateQ;
      byteIdxD  = byteIdxQ;
      writeIdxD = writeIdxQ;
      gapCntD   = gapCntQ;
      errD      = errQ;
      latchCfg  = 1'b0;
      wrReq     = 1'b0;
      case (stateQ)
         IDLE: begin
            if (i_START) begin
               latchCfg  = 1'b1;
               errD      = 1'b0;
               byteIdxD  = '0;
               writeIdxD = '0;
               gapCntD   = '0;
               wrReq     = 1'b1;
               stateD    = SETUP;
            end
         end
         SETUP: begin
            if (wrTimeout) begin
               errD   = 1'b1;
               stateD = IDLE;
            end else if (wrDone) begin
               if (writeIdxQ == 2'd2) begin
                  writeIdxD = '0;
                  gapCntD   = '0;
                  stateD    = GAP;
               end else begin
                  writeIdxD = writeIdxQ + 2'd1;
                  wrReq     = 1'b1;
               end
            end
         end
         GAP: begin
            if (gapCntQ == GAP_LAST) begin
               gapCntD = '0;
               if (byteIdxQ == LAST_BYTE) begin
                  stateD = FINISH;
               end else begin
                  byteIdxD = byteIdxQ + 4'd1;
                  wrReq    = 1'b1;
                  stateD   = SETUP;
               end
            end else begin
               gapCntD = gapCntQ + GAP_W'(1);
            end
         end
         FINISH: begin
            stateD = IDLE;
         end
         default: begin
            stateD = IDLE;
         end
      endcase
   end

   // Byte to send for the current byte index.
   always_comb begin
      txByte = 8'h00;
      case (byteIdxQ)
         4'd0:    txByte = OP_F8;
         4'd1:    txByte = cntRxQ[15:8];
         4'd2:    txByte = cntRxQ[7:0];
         4'd3:    txByte = OP_F9;
         4'd4:    txByte = cntTxQ[15:8];
         4'd5:    txByte = cntTxQ[7:0];
         4'd6:    txByte = OP_FA;
         4'd7:    txByte = oscQ;
         4'd8:    txByte = OP_FB;
         4'd9:    txByte = arthurQ;
         default: txByte = 8'h00;
      endcase
   end

   // Address/data of the current write within the byte's CONFIG/TX/CMD triple.
   always_comb begin
      wrAddr = ADDR_CMD;
      wrData = CMD_GO;
      case (writeIdxQ)
         2'd0: begin
            wrAddr = ADDR_CONFIG;
            wrData = cfgWord(modeQ, slaveQ, sckQ);
         end
         2'd1: begin
            wrAddr = ADDR_TX;
            wrData = txByte;
         end
         default: begin
            wrAddr = ADDR_CMD;
            wrData = CMD_GO;
         end
      endcase
   end

   apb_wr_master #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) uApb (
      .clk_i     (i_PCLK),
      .rst_i     (i_PRESET),
      .req_i     (wrReq),
      .addr_i    (wrAddr),
      .data_i    (wrData),
      .pready_i  (i_PREADY),
      .psel_o    (o_PSEL),
      .penable_o (o_PENABLE),
      .pwrite_o  (o_PWRITE),
      .paddr_o   (o_PADDR),
      .pwdata_o  (o_PWDATA),
      .done_o    (wrDone),
      .timeout_o (wrTimeout)
   );

   assign o_BUSY   = (stateQ == SETUP) || (stateQ == GAP);
   assign o_CONFIG = o_BUSY;
   assign o_DONE   = (stateQ == FINISH);
   assign o_ERR    = TIMEOUT_EN ? errQ : 1'b0;

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// tb_spi_cfg_sequencer: scoreboard bench for spi_cfg_sequencer.
// Every accepted start pushes the 30 expected APB writes; the bus monitor
// pops one per completed write. Timeout case needs SPI_CFG_PREADY_TIMEOUT_EN.
module tb_spi_cfg_sequencer;

   localparam int GAP     = 72;
   localparam int SEQ_LEN = 10 * (9 + GAP);

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  mode = '0, slave = '0, sck = '0;
   logic [15:0] cntRx = '0, cntTx = '0;
   logic [7:0]  oscFreq = '0, arthur = '0;
   logic        pready = 1'b1;

   logic        psel, penable, pwrite;
   logic [15:0] paddr;
   logic [7:0]  pwdata;
   logic        cfgStrobe, busy, done, err;

   int          cycle = 0;
   int          waitStates = 0;
   int          accessCnt = 0;
   logic [15:0] setupAddr = '0;
   logic [7:0]  setupData = '0;
   bit          armFirstSetup = 1'b0;
   int          firstSetupCycle = 0;
   int          startCycle = 0;
   int          writesDone = 0;
   int          doneCount = 0;
   logic [23:0] sbQueue [$];
   int          assertCount = 0;
   int          failCount = 0;

   spi_cfg_sequencer #(
      .GAP_CYCLES     (GAP),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .i_PCLK     (clock),
      .i_PRESET   (reset),
      .i_START    (start),
      .i_MODE     (mode),
      .i_SLAVE    (slave),
      .i_SCK      (sck),
      .i_CNT_RX   (cntRx),
      .i_CNT_TX   (cntTx),
      .i_OSC_FREQ (oscFreq),
      .i_ARTHUR   (arthur),
      .i_PREADY   (pready),
      .o_PSEL     (psel),
      .o_PENABLE  (penable),
      .o_PWRITE   (pwrite),
      .o_PADDR    (paddr),
      .o_PWDATA   (pwdata),
      .o_CONFIG   (cfgStrobe),
      .o_BUSY     (busy),
      .o_DONE     (done),
      .o_ERR      (err)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clock = ~clock;

   // Cycle counter used for latency measurements.
   always @(posedge clock) cycle++;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cycle);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Reference model: the 30 writes a start with these values must produce.
   task automatic pushSequence(input logic [15:0] rx, input logic [15:0] tx,
                               input logic [7:0] osc, input logic [7:0] art,
                               input logic [1:0] m, input logic [1:0] s, input logic [1:0] k);
      logic [7:0] seqBytes [10];
      seqBytes = '{8'hF8, rx[15:8], rx[7:0], 8'hF9, tx[15:8], tx[7:0], 8'hFA, osc, 8'hFB, art};
      for (int i = 0; i < 10; i++) begin
         sbQueue.push_back({16'h0040, 2'b00, m, s, k});
         sbQueue.push_back({16'h0044, seqBytes[i]});
         sbQueue.push_back({16'h004C, 8'h02});
      end
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "_psel"},    32'(psel),      0);
      checkOutput({tag, "_penable"}, 32'(penable),   0);
      checkOutput({tag, "_pwrite"},  32'(pwrite),    0);
      checkOutput({tag, "_paddr"},   32'(paddr),     0);
      checkOutput({tag, "_pwdata"},  32'(pwdata),    0);
      checkOutput({tag, "_config"},  32'(cfgStrobe), 0);
      checkOutput({tag, "_busy"},    32'(busy),      0);
      checkOutput({tag, "_done"},    32'(done),      0);
      checkOutput({tag, "_err"},     32'(err),       0);
   endtask

   // Called at posedge+1; holds start for one cycle.
   task automatic applyStimulus(input logic [15:0] rx, input logic [15:0] tx,
                                input logic [7:0] osc, input logic [7:0] art,
                                input logic [1:0] m, input logic [1:0] s, input logic [1:0] k,
                                input bit expectAccept);
      cntRx = rx; cntTx = tx; oscFreq = osc; arthur = art;
      mode = m; slave = s; sck = k;
      start = 1'b1;
      if (expectAccept) begin
         pushSequence(rx, tx, osc, art, m, s, k);
         armFirstSetup = 1'b1;
         startCycle = cycle;
      end
      tick();
      start = 1'b0;
      if (expectAccept) begin
         checkOutput("busyAfterStart",   32'(busy),      1);
         checkOutput("configAfterStart", 32'(cfgStrobe), 1);
         checkOutput("errAfterStart",    32'(err),       0);
      end else begin
         checkOutput("busyHeldOnStart",  32'(busy),      1);
      end
   endtask

   // Waits for o_DONE and checks the sequence length and scoreboard state.
   task automatic finishSequence(input int expLen, input int doneBase);
      bit seen = 1'b0;
      int seenCycle = 0;
      for (int i = 0; i < expLen + 40 && !seen; i++) begin
         @(negedge clock);
         if (done) begin
            seen = 1'b1;
            seenCycle = cycle;
            checkOutput("busyInFinish",   32'(busy),      0);
            checkOutput("configInFinish", 32'(cfgStrobe), 0);
         end
      end
      checkOutput("doneSeen", 32'(seen), 1);
      if (seen) checkOutput("seqLength", seenCycle - firstSetupCycle, expLen);
      checkOutput("setupLatency", firstSetupCycle - startCycle, 1);
      tick();
      checkOutput("donePulseWidth", 32'(done), 0);
      checkOutput("doneCount", doneCount - doneBase, 1);
      checkOutput("sbDrained", sbQueue.size(), 0);
   endtask

   // Advances until the ACCESS phase of write number 'target' is on the bus.
   task automatic waitAccess(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         tick();
         if (writesDone >= target && psel && penable) ok = 1'b1;
      end
   endtask

   // Bus monitor: stability checks, scoreboard pops and PREADY wait-state generation.
   always @(negedge clock) begin
      logic [23:0] expWrite;
      if (psel && !penable) begin
         setupAddr = paddr;
         setupData = pwdata;
         accessCnt = 0;
         pready    = 1'b0;
         checkOutput("setupPwrite", 32'(pwrite), 1);
         if (armFirstSetup) begin
            firstSetupCycle = cycle;
            armFirstSetup = 1'b0;
         end
      end else if (psel && penable) begin
         accessCnt++;
         checkOutput("addrStable",   32'(paddr),  32'(setupAddr));
         checkOutput("dataStable",   32'(pwdata), 32'(setupData));
         checkOutput("accessPwrite", 32'(pwrite), 1);
         pready = (accessCnt > waitStates);
         if (pready) begin
            if (sbQueue.size() != 0) expWrite = sbQueue.pop_front();
            else expWrite = 'x;
            checkOutput("writeAddr", 32'(paddr),  32'(expWrite[23:8]));
            checkOutput("writeData", 32'(pwdata), 32'(expWrite[7:0]));
            writesDone++;
         end
      end else begin
         checkOutput("idlePaddr",   32'(paddr),   0);
         checkOutput("idlePwdata",  32'(pwdata),  0);
         checkOutput("idlePenable", 32'(penable), 0);
         checkOutput("idlePwrite",  32'(pwrite),  0);
      end
      if (done) doneCount++;
   end

   initial begin
      bit ok;
      int base;
      int wbase;

      // Reset state
      repeat (3) tick();
      checkIdleOutputs("reset");
      reset = 1'b0;
      tick();
      checkIdleOutputs("postReset");

      // Nominal sequence, no wait states
      $display("[TB] nominal sequence");
      waitStates = 0;
      base = doneCount;
      applyStimulus(16'h2710, 16'h2500, 8'h03, 8'h0D, 2'b10, 2'b01, 2'b10, 1'b1);
      finishSequence(SEQ_LEN, base);

      // Back-to-back start in the cycle right after o_DONE
      $display("[TB] back-to-back start");
      base = doneCount;
      applyStimulus(16'hBEEF, 16'h0102, 8'h55, 8'hA5, 2'b00, 2'b11, 2'b01, 1'b1);
      finishSequence(SEQ_LEN, base);

      // Three wait states on every ACCESS
      $display("[TB] wait states");
      tick();
      waitStates = 3;
      base = doneCount;
      applyStimulus(16'h0F0F, 16'hA55A, 8'h7E, 8'h81, 2'b11, 2'b10, 2'b00, 1'b1);
      finishSequence(SEQ_LEN + 30 * 3, base);
      waitStates = 0;

      // Start pulse during byte 4 must be ignored
      $display("[TB] start while busy");
      tick();
      base = doneCount;
      wbase = writesDone;
      applyStimulus(16'h1357, 16'h2468, 8'h9A, 8'h42, 2'b01, 2'b10, 2'b11, 1'b1);
      waitAccess(wbase + 12, 1000, ok);
      checkOutput("reachedByte4", 32'(ok), 1);
      applyStimulus(16'hFFFF, 16'hEEEE, 8'hDD, 8'hCC, 2'b11, 2'b00, 2'b00, 1'b0);
      finishSequence(SEQ_LEN, base);

      // Reset during ACCESS of byte 5
      $display("[TB] mid-transfer reset");
      tick();
      base = doneCount;
      wbase = writesDone;
      applyStimulus(16'h4321, 16'h8765, 8'h11, 8'h22, 2'b01, 2'b01, 2'b01, 1'b1);
      waitAccess(wbase + 15, 1000, ok);
      checkOutput("reachedByte5", 32'(ok), 1);
      reset = 1'b1;
      tick();
      checkIdleOutputs("midReset");
      reset = 1'b0;
      sbQueue.delete();
      repeat (200) tick();
      checkOutput("noDoneAfterReset", doneCount - base, 0);
      base = doneCount;
      applyStimulus(16'h0001, 16'h0203, 8'h04, 8'h05, 2'b10, 2'b10, 2'b11, 1'b1);
      finishSequence(SEQ_LEN, base);

`ifdef SPI_CFG_PREADY_TIMEOUT_EN
      // PREADY stuck low
      $display("[TB] PREADY timeout");
      tick();
      waitStates = 1000;
      base = doneCount;
      applyStimulus(16'h5555, 16'hAAAA, 8'h66, 8'h99, 2'b00, 2'b01, 2'b10, 1'b1);
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         tick();
         if (err) ok = 1'b1;
      end
      checkOutput("errRaised",           32'(ok),        1);
      checkOutput("timeoutAccessCycles", accessCnt,      16);
      checkOutput("timeoutConfig",       32'(cfgStrobe), 0);
      checkOutput("timeoutBusy",         32'(busy),      0);
      checkOutput("timeoutPsel",         32'(psel),      0);
      checkOutput("timeoutPenable",      32'(penable),   0);
      sbQueue.delete();
      waitStates = 0;
      repeat (5) tick();
      checkOutput("errSticky",       32'(err),  1);
      checkOutput("noDoneOnTimeout", doneCount - base, 0);
      base = doneCount;
      applyStimulus(16'h2710, 16'h2500, 8'h03, 8'h0D, 2'b00, 2'b11, 2'b01, 1'b1);
      finishSequence(SEQ_LEN, base);
`endif

      repeat (5) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
